// File: rtl/acc_mem_pkg.sv
// Shared types and default widths for the accelerator memory arbiter.
package acc_mem_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_RD_DATA_W = 512;
  localparam int DEF_WR_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/acc_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last-granted index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s          = IDX_W'((int'(ptr) + k) % NUM_REQ);
      hit_s          = req[idx_s] & ~grant_any;
      grant[idx_s]   = grant[idx_s] | hit_s;
      grant_idx      = hit_s ? idx_s : grant_idx;
      grant_any      = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter of accelerator read/write requests onto one
// single-ported data memory; one transaction in flight at a time.
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int RD_DATA_W      = DEF_RD_DATA_W,
  parameter int WR_DATA_W      = DEF_WR_DATA_W,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_rd_addr,
  input  logic [NUM_REQ-1:0]             req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_wr_addr,
  input  logic [NUM_REQ*WR_DATA_W-1:0]   req_wr_data,
  output logic [RD_DATA_W-1:0]           rd_data,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [NUM_REQ-1:0]             wr_done,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [WR_DATA_W-1:0]           mem_wdata,
  input  logic [RD_DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_RD_LATENCY + 1);

  arb_state_t             state_r;
  arb_state_t             state_nxt_s;
  logic [IDX_W-1:0]       ptr_r;
  logic [IDX_W-1:0]       lat_port_r;
  op_t                    lat_op_r;
  logic [ADDR_W-1:0]      lat_addr_r;
  logic [WR_DATA_W-1:0]   lat_wdata_r;
  logic [CNT_W-1:0]       cnt_r;

  logic [RD_DATA_W-1:0]   rd_data_r;
  logic [NUM_REQ-1:0]     rd_valid_r;
  logic [NUM_REQ-1:0]     wr_done_r;
  logic                   mem_en_r;

  logic [NUM_REQ-1:0]     req_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   grant_any_s;
  logic                   win_rd_s;
  logic [ADDR_W-1:0]      win_addr_s;
  logic [WR_DATA_W-1:0]   win_wdata_s;
  logic                   rd_done_s;
  logic                   mem_en_nxt_s;
  logic [NUM_REQ-1:0]     rsp_onehot_s;
  logic [NUM_REQ-1:0]     rd_valid_nxt_s;
  logic [NUM_REQ-1:0]     wr_done_nxt_s;

  assign req_s = req_rd_en | req_wr_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Winner's operands; a port holding both enables is served as a read first.
  always_comb begin
    win_rd_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_rd_s    = win_rd_s | (grant_s[i] & req_rd_en[i]);
      win_addr_s  = win_addr_s | ({ADDR_W{grant_s[i]}} &
                    (req_rd_en[i] ? req_rd_addr[i*ADDR_W +: ADDR_W]
                                  : req_wr_addr[i*ADDR_W +: ADDR_W]));
      win_wdata_s = win_wdata_s |
                    ({WR_DATA_W{grant_s[i]}} & req_wr_data[i*WR_DATA_W +: WR_DATA_W]);
    end
  end

  assign rd_done_s = (state_r == RD_WAIT) && (cnt_r == CNT_W'(MEM_RD_LATENCY));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB:     state_nxt_s = grant_any_s ? ISSUE : ARB;
      ISSUE:   state_nxt_s = (lat_op_r == OP_RD) ? RD_WAIT : RESP;
      RD_WAIT: state_nxt_s = rd_done_s ? RESP : RD_WAIT;
      RESP:    state_nxt_s = ARB;
      default: state_nxt_s = ARB;
    endcase
  end

  // Next values of the registered outputs; responses go to the latched port only.
  always_comb begin
    mem_en_nxt_s   = (state_r == ARB) && grant_any_s;
    rsp_onehot_s   = NUM_REQ'(1'b1) << lat_port_r;
    rd_valid_nxt_s = '0;
    wr_done_nxt_s  = '0;
    case (state_r)
      ISSUE: begin
        if (lat_op_r == OP_WR) begin
          wr_done_nxt_s = rsp_onehot_s;
        end else begin
          wr_done_nxt_s = '0;
        end
      end
      RD_WAIT: begin
        if (rd_done_s) begin
          rd_valid_nxt_s = rsp_onehot_s;
        end else begin
          rd_valid_nxt_s = '0;
        end
      end
      default: begin
        rd_valid_nxt_s = '0;
        wr_done_nxt_s  = '0;
      end
    endcase
  end

  // Transaction latch, pointer, latency counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= IDX_W'(NUM_REQ - 1);
      lat_port_r  <= '0;
      lat_op_r    <= OP_RD;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
      cnt_r       <= '0;
      rd_data_r   <= '0;
      rd_valid_r  <= '0;
      wr_done_r   <= '0;
      mem_en_r    <= 1'b0;
    end else begin
      mem_en_r   <= mem_en_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      wr_done_r  <= wr_done_nxt_s;
      if (mem_en_nxt_s) begin
        ptr_r      <= grant_idx_s;
        lat_port_r <= grant_idx_s;
        lat_op_r   <= win_rd_s ? OP_RD : OP_WR;
        lat_addr_r <= win_addr_s;
        if (!win_rd_s) begin
          lat_wdata_r <= win_wdata_s;
        end
      end
      // cnt_r tracks cycles elapsed since the ISSUE cycle.
      if (state_r == ISSUE) begin
        cnt_r <= CNT_W'(1);
      end else if ((state_r == RD_WAIT) && !rd_done_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (rd_done_s) begin
        rd_data_r <= mem_rdata;
      end
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign wr_done   = wr_done_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = (lat_op_r == OP_WR);
  assign mem_addr  = lat_addr_r;
  assign mem_wdata = lat_wdata_r;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench: instance u_dut0 at read latency 1, u_dut1 at read latency 3.
module tb_acc_mem_arbiter;

  localparam logic [511:0] FILL = {16{32'hDEADBEEF}};

  logic clk;
  logic rst_n;

  logic [3:0]   rd_en0, wr_en0;
  logic [63:0]  rd_addr0, wr_addr0;
  logic [127:0] wr_data0;
  logic [511:0] rd_data0, mem_rdata0, mem_line0;
  logic [3:0]   rd_valid0, wr_done0;
  logic         mem_en0, mem_we0;
  logic [15:0]  mem_addr0;
  logic [31:0]  mem_wdata0;

  logic [3:0]   rd_en1, wr_en1;
  logic [63:0]  rd_addr1, wr_addr1;
  logic [127:0] wr_data1;
  logic [511:0] rd_data1, mem_rdata1;
  logic [511:0] rdq1 [3];
  logic [3:0]   rd_valid1, wr_done1;
  logic         mem_en1, mem_we1;
  logic [15:0]  mem_addr1;
  logic [31:0]  mem_wdata1;

  int n_checks;
  int n_fails;

  acc_mem_arbiter #(.MEM_RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(rd_en0), .req_rd_addr(rd_addr0),
    .req_wr_en(wr_en0), .req_wr_addr(wr_addr0), .req_wr_data(wr_data0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .wr_done(wr_done0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  acc_mem_arbiter #(.MEM_RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(rd_en1), .req_rd_addr(rd_addr1),
    .req_wr_en(wr_en1), .req_wr_addr(wr_addr1), .req_wr_data(wr_data1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .wr_done(wr_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data valid exactly L cycles after the read strobe, filler otherwise.
  always @(posedge clk) begin
    mem_rdata0 <= (mem_en0 && !mem_we0) ? mem_line0 : FILL;
    rdq1[0]    <= (mem_en1 && !mem_we1) ? {32{mem_addr1}} : FILL;
    rdq1[1]    <= rdq1[0];
    rdq1[2]    <= rdq1[1];
  end
  assign mem_rdata1 = rdq1[2];

  task automatic check_value(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [15:0] a);
    rd_en0[p] = 1'b1;
    rd_addr0[p*16 +: 16] = a;
  endtask

  task automatic set_wr(input int p, input logic [15:0] a, input logic [31:0] d);
    wr_en0[p] = 1'b1;
    wr_addr0[p*16 +: 16] = a;
    wr_data0[p*32 +: 32] = d;
  endtask

  task automatic check_idle0(input string tag);
    check_value({tag, "_mem_en"}, 512'(mem_en0), 512'(1'b0));
    check_value({tag, "_rd_valid"}, 512'(rd_valid0), 512'(4'b0000));
    check_value({tag, "_wr_done"}, 512'(wr_done0), 512'(4'b0000));
  endtask

  int seq [7] = '{0, 1, 2, 3, 0, 2, 3};

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    rd_en0 = '0; wr_en0 = '0; rd_addr0 = '0; wr_addr0 = '0; wr_data0 = '0;
    rd_en1 = '0; wr_en1 = '0; rd_addr1 = '0; wr_addr1 = '0; wr_data1 = '0;
    mem_line0 = '0;
    repeat (3) tick();

    // Reset values.
    check_idle0("rst");
    check_value("rst_rd_data", rd_data0, 512'(0));
    check_value("rst_mem_addr", 512'(mem_addr0), 512'(16'h0));
    check_value("rst_mem_we", 512'(mem_we0), 512'(1'b0));
    check_value("rst_mem_wdata", 512'(mem_wdata0), 512'(32'h0));
    check_value("rst_mem_en1", 512'(mem_en1), 512'(1'b0));
    rst_n = 1'b1;

    // Single read, port 2.
    set_rd(2, 16'h1000);
    mem_line0 = {64{8'hA5}};
    tick();
    check_value("rd_issue_en", 512'(mem_en0), 512'(1'b1));
    check_value("rd_issue_we", 512'(mem_we0), 512'(1'b0));
    check_value("rd_issue_addr", 512'(mem_addr0), 512'(16'h1000));
    tick();
    check_idle0("rd_wait");
    tick();
    check_value("rd_valid", 512'(rd_valid0), 512'(4'b0100));
    check_value("rd_data", rd_data0, {64{8'hA5}});
    check_value("rd_no_wr_done", 512'(wr_done0), 512'(4'b0000));
    rd_en0[2] = 1'b0;
    tick();
    check_idle0("rd_after");

    // Single write, port 0.
    set_wr(0, 16'h5000, 32'h5);
    tick();
    check_value("wr_issue_en", 512'(mem_en0), 512'(1'b1));
    check_value("wr_issue_we", 512'(mem_we0), 512'(1'b1));
    check_value("wr_issue_addr", 512'(mem_addr0), 512'(16'h5000));
    check_value("wr_issue_wdata", 512'(mem_wdata0), 512'(32'h5));
    tick();
    check_value("wr_done", 512'(wr_done0), 512'(4'b0001));
    check_value("rd_data_hold", rd_data0, {64{8'hA5}});
    wr_en0[0] = 1'b0;
    tick();
    check_idle0("wr_after");

    // Port 1 read and write together: read first, write later.
    set_rd(1, 16'h2000);
    set_wr(1, 16'h3000, 32'h77);
    mem_line0 = {16{32'h12345678}};
    tick();
    check_value("rw_rd_we", 512'(mem_we0), 512'(1'b0));
    check_value("rw_rd_addr", 512'(mem_addr0), 512'(16'h2000));
    tick();
    tick();
    check_value("rw_rd_valid", 512'(rd_valid0), 512'(4'b0010));
    check_value("rw_rd_no_done", 512'(wr_done0), 512'(4'b0000));
    check_value("rw_rd_data", rd_data0, {16{32'h12345678}});
    rd_en0[1] = 1'b0;
    tick();
    check_idle0("rw_arb");
    tick();
    check_value("rw_wr_en", 512'(mem_en0), 512'(1'b1));
    check_value("rw_wr_we", 512'(mem_we0), 512'(1'b1));
    check_value("rw_wr_addr", 512'(mem_addr0), 512'(16'h3000));
    check_value("rw_wr_wdata", 512'(mem_wdata0), 512'(32'h77));
    tick();
    check_value("rw_wr_done", 512'(wr_done0), 512'(4'b0010));
    check_value("rw_wr_no_rdv", 512'(rd_valid0), 512'(4'b0000));
    wr_en0[1] = 1'b0;
    tick();

    // Read latency 3 on the second instance, port 1.
    rd_en1[1] = 1'b1;
    rd_addr1[16 +: 16] = 16'h4444;
    tick();
    check_value("l3_issue_en", 512'(mem_en1), 512'(1'b1));
    check_value("l3_issue_we", 512'(mem_we1), 512'(1'b0));
    tick();
    tick();
    tick();
    check_value("l3_early_rdv", 512'(rd_valid1), 512'(4'b0000));
    tick();
    check_value("l3_rd_valid", 512'(rd_valid1), 512'(4'b0010));
    check_value("l3_rd_data", rd_data1, {32{16'h4444}});
    rd_en1[1] = 1'b0;
    tick();
    check_value("l3_rdv_pulse", 512'(rd_valid1), 512'(4'b0000));

    // Contention from reset: all ports write; then ports drop one by one.
    rst_n = 1'b0;
    tick();
    tick();
    check_value("rst2_rd_data", rd_data0, 512'(0));
    check_idle0("rst2");
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) set_wr(p, 16'h6000 + 16'(p), 32'hC0 + 32'(p));
    for (int j = 0; j < 7; j++) begin
      tick();
      check_value($sformatf("cont%0d_en", j), 512'(mem_en0), 512'(1'b1));
      check_value($sformatf("cont%0d_addr", j), 512'(mem_addr0), 512'(16'h6000 + 16'(seq[j])));
      check_value($sformatf("cont%0d_wdata", j), 512'(mem_wdata0), 512'(32'hC0 + 32'(seq[j])));
      tick();
      check_value($sformatf("cont%0d_done", j), 512'(wr_done0), 512'(4'b0001 << seq[j]));
      if (j >= 4) wr_en0[seq[j]] = 1'b0;
      if (j == 4) wr_en0[1] = 1'b0;
      tick();
      check_idle0($sformatf("cont%0d_gap", j));
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      check_idle0($sformatf("cont_idle%0d", j));
    end

    // Reset during RD_WAIT abandons the read and restores the pointer.
    set_rd(0, 16'h7000);
    mem_line0 = {64{8'h3C}};
    tick();
    check_value("mid_issue_en", 512'(mem_en0), 512'(1'b1));
    tick();
    rst_n = 1'b0;
    rd_en0[0] = 1'b0;
    tick();
    check_idle0("mid_rst");
    check_value("mid_rst_rd_data", rd_data0, 512'(0));
    check_value("mid_rst_addr", 512'(mem_addr0), 512'(16'h0));
    rst_n = 1'b1;
    set_wr(3, 16'h8003, 32'h33);
    set_wr(0, 16'h8000, 32'h30);
    tick();
    check_value("post_rst_addr0", 512'(mem_addr0), 512'(16'h8000));
    tick();
    check_value("post_rst_done0", 512'(wr_done0), 512'(4'b0001));
    check_value("post_rst_no_rdv", 512'(rd_valid0), 512'(4'b0000));
    wr_en0[0] = 1'b0;
    tick();
    tick();
    check_value("post_rst_addr3", 512'(mem_addr0), 512'(16'h8003));
    tick();
    check_value("post_rst_done3", 512'(wr_done0), 512'(4'b1000));
    wr_en0[3] = 1'b0;
    tick();
    check_idle0("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/acc_mem_arbiter.md
Name: acc_mem_arbiter

Overview:
- Responder side of the accelerator memory-request protocol. Accelerator control units hold a read or write request until this block answers with a one-cycle rd_valid or wr_done.
- Arbitrates NUM_REQ accelerator request ports round-robin onto one single-ported Data Memory port with fixed read latency.
- Returns 512-bit read lines and acknowledges 32-bit writes. Sits between the accelerator array and Data Memory.

Parameters:
- NUM_REQ, 4, number of accelerator request ports.
- ADDR_W, 16, request and memory address width; addresses pass through unmodified.
- RD_DATA_W, 512, read line width.
- WR_DATA_W, 32, write word width.
- MEM_RD_LATENCY, 1, cycles from the memory issue cycle to mem_rdata valid (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_rd_en  in  NUM_REQ  per-port read request, level, held until rd_valid.
- req_rd_addr  in  NUM_REQ*ADDR_W  per-port read address, packed, port i at [i*ADDR_W +: ADDR_W].
- req_wr_en  in  NUM_REQ  per-port write request, level, held until wr_done.
- req_wr_addr  in  NUM_REQ*ADDR_W  per-port write address, packed.
- req_wr_data  in  NUM_REQ*WR_DATA_W  per-port write data, packed.
- rd_data  out  RD_DATA_W  shared read data; valid only where that port's rd_valid is high.
- rd_valid  out  NUM_REQ  one-hot, one-cycle read completion.
- wr_done  out  NUM_REQ  one-hot, one-cycle write completion.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WR_DATA_W  memory write data.
- mem_rdata  in  RD_DATA_W  memory read data, valid MEM_RD_LATENCY cycles after the mem_en cycle.

Behaviour:
- All outputs registered. Reset values:
  - rd_data, rd_valid, wr_done, mem_en, mem_we, mem_addr, mem_wdata = 0.
  - state = ARB.
  - rr pointer (last granted) = NUM_REQ-1, so port 0 has highest priority after reset.
- FSM states:
  - ARB: per-port request = rd_en|wr_en. If any request is set, pick the first requesting port scanning from pointer+1 modulo NUM_REQ. Latch the port index, op, address and data. Update pointer to the winner. Next state ISSUE. If no request, stay in ARB.
  - ISSUE: mem_en=1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the latch. Next: RD_WAIT for a read, RESP for a write.
  - RD_WAIT: count MEM_RD_LATENCY cycles from ISSUE. Capture mem_rdata into rd_data on the cycle it is valid. Next RESP.
  - RESP: for the latched port only, rd_valid[i]=1 (read) or wr_done[i]=1 (write) for exactly one cycle. Next ARB.
- Latency from a request sampled in ARB at cycle t (no contention):
  - write: wr_done at t+2.
  - read: rd_valid at t+2+MEM_RD_LATENCY (t+3 at default).
- Requester contract: the requester drops or changes its request in the cycle after the response. Because ARB follows RESP, a completed request is never re-granted.
- If a port asserts rd_en and wr_en together, the read is served first; the write remains pending and competes in a later ARB.
- Once a transaction is latched, it completes and its response pulses even if the requester deasserts mid-transaction.
- Throughput: one transaction per 3 cycles for writes, per 3+MEM_RD_LATENCY cycles for reads. No pipelining or overlap.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,3,0,... No port waits more than NUM_REQ-1 transactions.
- rd_data holds its last captured value between reads.
- Reset mid-transaction: the transaction is abandoned, no response is issued, state returns to ARB, pointer returns to NUM_REQ-1.
- rd_valid|wr_done is at most one-hot across all ports and both signals. mem_en is never high in two consecutive cycles.

Decomposition:
- Package acc_mem_pkg:
  - arb_state_t enum: ARB, ISSUE, RD_WAIT, RESP.
  - op_t enum: OP_RD, OP_WR.
  - default width constants: 16, 512, 32.
- Sub-module rr_arbiter:
  - inputs: NUM_REQ request vector, pointer.
  - outputs: one-hot grant and grant index (combinational).
  - the top level owns the pointer register.

Test Plan:
- Single read: port 2 reads 16'h1000, memory returns 512'hA5..A5 at L=1 -> exactly one mem_en with mem_we=0 at t+1; rd_valid=4'b0100 at t+3 with rd_data=512'hA5..A5.
- Single write: port 0 writes 32'h5 to 16'h5000 -> mem_en=1, mem_we=1, mem_addr=16'h5000, mem_wdata=32'h5 at t+1; wr_done=4'b0001 at t+2.
- Contention: all four ports request writes continuously from reset -> grant order 0,1,2,3,0. Each wr_done spaced 3 cycles apart, no duplicate grant for a port whose request dropped after its done.
- Same port rd_en and wr_en together -> read serviced and rd_valid pulses first; the write's wr_done follows in a later transaction.
- MEM_RD_LATENCY=3: port 1 read -> rd_valid at t+5; rd_data equals mem_rdata sampled 3 cycles after the mem_en cycle.
- rst_n low during RD_WAIT -> no rd_valid pulse, all outputs 0 next cycle. After release, simultaneous requests on ports 3 and 0 are granted to port 0 first.
